irq_arbiter: RTL and testbench

//  Bus-mapped interrupt controller between the peripherals (timer, UART, keys, ...) and the CPU HWInt inputs.

---
 rtl/irq_arbiter_pkg.sv | 17 +
 rtl/irq_arbiter_prio_enc.sv | 19 +
 rtl/irq_arbiter.sv | 152 +++++++++++++++
 tb/tb_irq_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: FSM encoding, register word indices, ID values.
package irq_arbiter_pkg;

    typedef logic [2:0] irq_id_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_CFG  = 2'd2;
    localparam logic [1:0] REG_CUR  = 2'd3;

    localparam irq_id_t ID_NONE = 3'd7;

endpackage

// File: rtl/irq_arbiter_prio_enc.sv
// Fixed-priority encoder: ID of the lowest set bit of vec, or ID_NONE when vec is zero.
module irq_prio_enc #(
    parameter int         N_SRC   = 6,
    parameter logic [2:0] ID_NONE = 3'd7
) (
    input  logic [N_SRC-1:0] vec,
    output logic [2:0]       id
);
    import irq_arbiter_pkg::*;

    always_comb begin
        id = ID_NONE;
        // Walk downwards so the lowest index is the last (winning) assignment.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) id = irq_id_t'(i);
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Bus-mapped interrupt controller: latches, masks and prioritises sources, sequences REQ/ack/EOI.
// Define IRQ_SYNC_EN to pass irq_src through a 2-flop synchroniser before edge/level detection.
//
//   state   | meaning
//   IDLE    | no interrupt selected; CUR = ID_NONE, waiting for a masked pend
//   REQ     | CUR selected, irq_out high, waiting for CPU read (ack) or write (ack+EOI)
//   SERVICE | acknowledged, irq_out low, no preemption until EOI write to CUR
module irq_arbiter #(
    parameter int         N_SRC   = 6,
    parameter logic [2:0] ID_NONE = 3'd7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic             rd_en,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [N_SRC-1:0] irq_src,
    output logic             irq_out
);
    import irq_arbiter_pkg::*;

    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] src_hist;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend, pend_n;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] cfg;
    logic [N_SRC-1:0] req_vec;
    logic [N_SRC-1:0] cur_hot;
    logic [N_SRC-1:0] clr;
    logic [1:0]       state, state_n;
    irq_id_t          cur, cur_n, enc_id;
    logic             wr_cur, rd_cur, eoi, active;
    logic             unused_wdata;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            src_s  <= '0;
        end else begin
            sync_q <= irq_src;
            src_s  <= sync_q;
        end
    end
`else
    assign src_s = irq_src;
`endif

    assign rise    = src_s & ~src_hist;
    assign req_vec = pend & mask;
    assign wr_cur  = we && (addr == REG_CUR);
    assign rd_cur  = rd_en && (addr == REG_CUR);
    assign eoi     = wr_cur && (state != IDLE);
    assign active  = |(req_vec & cur_hot);

    assign unused_wdata = ^wdata[31:N_SRC];

    always_comb begin
        cur_hot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cur_hot[i] = (cur == irq_id_t'(i));
        end
    end

    irq_prio_enc #(
        .N_SRC   (N_SRC),
        .ID_NONE (ID_NONE)
    ) u_prio_enc (
        .vec (req_vec),
        .id  (enc_id)
    );

    // Edge pends: a new rising edge wins over a same-cycle W1C/EOI clear; level pends follow src.
    always_comb begin
        clr    = eoi ? cur_hot : '0;
        pend_n = '0;
        if (we && (addr == REG_PEND)) clr = clr | wdata[N_SRC-1:0];
        for (int i = 0; i < N_SRC; i++) begin
            pend_n[i] = cfg[i] ? (rise[i] | (pend[i] & ~clr[i])) : src_s[i];
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur;
        case (state)
            IDLE: begin
                if (|req_vec) begin
                    cur_n   = enc_id;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (wr_cur) begin
                    cur_n   = ID_NONE;
                    state_n = IDLE;
                end else if (rd_cur) begin
                    state_n = SERVICE;
                end else if (!active) begin
                    cur_n   = ID_NONE;
                    state_n = IDLE;
                end
            end
            SERVICE: begin
                if (wr_cur) begin
                    cur_n   = ID_NONE;
                    state_n = IDLE;
                end
            end
            default: begin
                cur_n   = ID_NONE;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cur      <= ID_NONE;
            irq_out  <= 1'b0;
            src_hist <= '0;
            pend     <= '0;
            mask     <= '0;
            cfg      <= '0;
        end else begin
            state    <= state_n;
            cur      <= cur_n;
            irq_out  <= (state_n == REQ);
            src_hist <= src_s;
            pend     <= pend_n;
            if (we && (addr == REG_MASK)) mask <= wdata[N_SRC-1:0];
            if (we && (addr == REG_CFG))  cfg  <= wdata[N_SRC-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_PEND: rdata[N_SRC-1:0] = pend;
            REG_MASK: rdata[N_SRC-1:0] = mask;
            REG_CFG:  rdata[N_SRC-1:0] = cfg;
            default:  rdata[2:0]       = cur;
        endcase
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter with a scoreboard queue of expected values.
module tb_irq_arbiter;
    import irq_arbiter_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  irq_src;
    logic        irq_out;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    irq_arbiter #(.N_SRC(6), .ID_NONE(3'd7)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .rd_en   (rd_en),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq_src (irq_src),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
        addr = a;
        #1;
        push(tag, v);
        pop_check(rdata);
    endtask

    task automatic chk_irq(input string tag, input logic v);
        push(tag, {31'b0, v});
        pop_check({31'b0, irq_out});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic ack(input string tag, input logic [31:0] v);
        addr  = REG_CUR;
        rd_en = 1'b1;
        #1;
        push(tag, v);
        pop_check(rdata);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        addr    = '0;
        we      = 1'b0;
        rd_en   = 1'b0;
        wdata   = '0;
        irq_src = '0;
        cyc(2);
        reset = 1'b0;

        // reset state
        chk_irq("rst_irq", 1'b0);
        chk_reg("rst_pend", REG_PEND, 32'h0);
        chk_reg("rst_mask", REG_MASK, 32'h0);
        chk_reg("rst_cfg",  REG_CFG,  32'h0);
        chk_reg("rst_cur",  REG_CUR,  32'h7);
        cyc(1);

        // single edge pulse, read-ack then EOI
        wr(REG_MASK, 32'h3F);
        wr(REG_CFG,  32'h3F);
        chk_reg("t2_mask", REG_MASK, 32'h3F);
        irq_src = 6'b000100;
        push("t2_lat_lo", 32'h0);
        push("t2_lat_hi", 32'h1);
        cyc(1);
        irq_src = '0;
        cyc(LAT - 2);
        pop_check({31'b0, irq_out});
        cyc(1);
        pop_check({31'b0, irq_out});
        ack("t2_cur", 32'h2);
        chk_irq("t2_ack_irq", 1'b0);
        chk_reg("t2_pend_svc", REG_PEND, 32'h4);
        wr(REG_CUR, 32'h0);
        chk_reg("t2_pend_eoi", REG_PEND, 32'h0);
        chk_reg("t2_cur_eoi",  REG_CUR,  32'h7);
        chk_irq("t2_eoi_irq", 1'b0);
        cyc(1);

        // two simultaneous edges: lower index first
        irq_src = 6'b010010;
        cyc(LAT);
        chk_irq("t3_req", 1'b1);
        chk_reg("t3_cur_first", REG_CUR, 32'h1);
        irq_src = '0;
        ack("t3_ack", 32'h1);
        wr(REG_CUR, 32'h0);
        chk_irq("t3_idle_gap", 1'b0);
        cyc(1);
        chk_irq("t3_req2", 1'b1);
        chk_reg("t3_cur_second", REG_CUR, 32'h4);
        wr(REG_CUR, 32'h0);
        chk_reg("t3_pend_clr", REG_PEND, 32'h0);
        chk_irq("t3_done_irq", 1'b0);
        cyc(1);

        // level source held high re-requests after one IDLE cycle
        wr(REG_CFG, 32'h0);
        irq_src = 6'b000001;
        cyc(LAT);
        chk_irq("t4_req", 1'b1);
        chk_reg("t4_cur", REG_CUR, 32'h0);
        wr(REG_CUR, 32'h0);
        chk_irq("t4_eoi_gap", 1'b0);
        chk_reg("t4_cur_gap", REG_CUR, 32'h7);
        chk_reg("t4_pend_level", REG_PEND, 32'h1);
        cyc(1);
        chk_irq("t4_rereq", 1'b1);
        chk_reg("t4_cur_again", REG_CUR, 32'h0);
        irq_src = '0;
        cyc(LAT);
        chk_irq("t4_withdraw", 1'b0);
        chk_reg("t4_cur_wd", REG_CUR, 32'h7);
        cyc(1);

        // masking the active source withdraws the request
        wr(REG_CFG, 32'h3F);
        irq_src = 6'b001000;
        cyc(1);
        irq_src = '0;
        cyc(LAT - 1);
        chk_irq("t5_req", 1'b1);
        chk_reg("t5_cur", REG_CUR, 32'h3);
        wr(REG_MASK, 32'h0);
        cyc(1);
        chk_irq("t5_mask_drop", 1'b0);
        chk_reg("t5_cur_none", REG_CUR, 32'h7);
        chk_reg("t5_pend_kept", REG_PEND, 32'h8);
        cyc(1);

        // async reset in SERVICE, checked before any clock edge
        wr(REG_MASK, 32'h3F);
        cyc(1);
        chk_irq("t6_req", 1'b1);
        ack("t6_ack", 32'h3);
        chk_irq("t6_svc_irq", 1'b0);
        chk_reg("t6_mask_pre", REG_MASK, 32'h3F);
        #1;
        reset = 1'b1;
        #1;
        chk_irq("t6_rst_irq", 1'b0);
        chk_reg("t6_rst_pend", REG_PEND, 32'h0);
        chk_reg("t6_rst_mask", REG_MASK, 32'h0);
        chk_reg("t6_rst_cfg",  REG_CFG,  32'h0);
        chk_reg("t6_rst_cur",  REG_CUR,  32'h7);
        cyc(1);
        reset = 1'b0;
        cyc(2);
        chk_irq("t6_post_rst_irq", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
